// File: rtl/proc_run_controller_if.sv
// Interface bundling the run-controller control inputs and core-facing outputs.
//   start/mode/budget/step/halt : launch and run-control requests (toward the controller)
//   core_reset/core_en          : reset and clock-enable driven to the processor
//   cycle_cnt                   : enabled-cycle count of the current or last run
//   busy/done                   : run in progress / one-cycle completion pulse
//   state_dbg                   : current FSM state code, for observation only
// Handshake: there is no valid/ready pair. start is a level sampled on the rising
// edge only while the controller is not busy. step acts on its 0->1 transition.
// halt is a level honoured on any edge while busy.
// master = the side issuing requests; slave = the controller.
interface proc_run_controller_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [1:0]       mode;
  logic [CNT_W-1:0] budget;
  logic             step;
  logic             halt;
  logic             core_reset;
  logic             core_en;
  logic [CNT_W-1:0] cycle_cnt;
  logic             busy;
  logic             done;
  logic [2:0]       state_dbg;

  modport master (
    output start, mode, budget, step, halt,
    input  core_reset, core_en, cycle_cnt, busy, done, state_dbg
  );

  modport slave (
    input  start, mode, budget, step, halt,
    output core_reset, core_en, cycle_cnt, busy, done, state_dbg
  );
endinterface

// File: rtl/proc_run_controller.sv
// Programmable run sequencer for the pipelined processor.
// It holds the core in reset for RST_CYCLES cycles after start. It then runs the
// core in free-run, budget or single-step mode through a clock-enable. It counts
// the enabled cycles, saturating at the maximum count, and pulses done on completion.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high
//   bus   : proc_run_controller_if.slave (requests in, core controls/status out)
// Every output is registered. Each one is computed from the next state, so it
// lines up with the state being entered.
module proc_run_controller #(
  parameter int RST_CYCLES = 2,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  proc_run_controller_if.slave  bus
);

  localparam int RC_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RST_LOAD = RC_W'(RST_CYCLES - 1);

  localparam logic [1:0] MODE_FREE   = 2'b00;
  localparam logic [1:0] MODE_BUDGET = 2'b01;
  localparam logic [1:0] MODE_STEP   = 2'b10;
  localparam logic [1:0] MODE_RSVD   = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RESET     = 3'd1,
    S_RUN       = 3'd2,
    S_STEP_WAIT = 3'd3,
    S_STEP      = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] budget_q;
  logic             step_q;
  logic             accept;
  logic [CNT_W-1:0] cnt_inc;

  // start is honoured only when idle or finished, and never for the reserved mode.
  assign accept  = ((state_q == S_IDLE) || (state_q == S_DONE)) &&
                   bus.start && (bus.mode != MODE_RSVD);
  // Saturating increment: stays at all-ones instead of wrapping.
  assign cnt_inc = (bus.cycle_cnt == '1) ? bus.cycle_cnt : bus.cycle_cnt + 1'b1;

  assign bus.state_dbg = state_q;

  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d   = S_RESET;
          rst_cnt_d = RST_LOAD;
        end
      end
      S_RESET: begin
        if (bus.halt) begin
          state_d = S_DONE;
        end else if (rst_cnt_q == '0) begin
          case (mode_q)
            MODE_FREE:   state_d = S_RUN;
            MODE_BUDGET: state_d = (budget_q == '0) ? S_DONE : S_RUN;
            default:     state_d = S_STEP_WAIT;
          endcase
        end else begin
          rst_cnt_d = rst_cnt_q - 1'b1;
        end
      end
      S_RUN: begin
        // core_en is high throughout RUN. The edge that lifts the count to the
        // budget therefore ends the last budgeted cycle.
        if (bus.halt) begin
          state_d = S_DONE;
        end else if ((mode_q == MODE_BUDGET) && (cnt_inc == budget_q)) begin
          state_d = S_DONE;
        end
      end
      S_STEP_WAIT: begin
        if (bus.halt) begin
          state_d = S_DONE;
        end else if (bus.step && !step_q) begin
          state_d = S_STEP;
        end
      end
      S_STEP: begin
        state_d = bus.halt ? S_DONE : S_STEP_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rst_cnt_q      <= '0;
      mode_q         <= '0;
      budget_q       <= '0;
      step_q         <= 1'b0;
      bus.core_reset <= 1'b1;
      bus.core_en    <= 1'b0;
      bus.cycle_cnt  <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
      step_q    <= bus.step;
      if (accept) begin
        mode_q        <= bus.mode;
        budget_q      <= bus.budget;
        bus.cycle_cnt <= '0;
      end else if (bus.core_en) begin
        bus.cycle_cnt <= cnt_inc;
      end
      bus.core_reset <= (state_d == S_IDLE) || (state_d == S_RESET);
      bus.core_en    <= (state_d == S_RUN) || (state_d == S_STEP);
      bus.busy       <= (state_d == S_RESET) || (state_d == S_RUN) ||
                        (state_d == S_STEP_WAIT) || (state_d == S_STEP);
      bus.done       <= (state_d == S_DONE) && (state_q != S_DONE);
    end
  end

endmodule

// File: tb/tb_proc_run_controller.sv
module tb_proc_run_controller;

  logic clk;
  logic reset;

  proc_run_controller_if #(.CNT_W(16)) bus ();
  proc_run_controller_if #(.CNT_W(4))  bus_s ();

  proc_run_controller #(.RST_CYCLES(2), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  proc_run_controller #(.RST_CYCLES(2), .CNT_W(4)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_s)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Independent core_en observer: total enabled cycles and rising edges.
  int   en_total  = 0;
  int   rise_total = 0;
  logic en_prev   = 1'b0;
  always @(negedge clk) begin
    if (bus.core_en === 1'b1) en_total++;
    if (bus.core_en === 1'b1 && en_prev !== 1'b1) rise_total++;
    en_prev = bus.core_en;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic        start;
    logic [1:0]  mode;
    logic [15:0] budget;
    logic        step;
    logic        halt;
    logic        core_reset;
    logic        core_en;
    logic [15:0] cnt;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic st, input logic [1:0] m, input logic [15:0] b,
                         input logic sp, input logic h, input logic cr, input logic en,
                         input logic [15:0] c, input logic bz, input logic dn);
    vec_t v;
    v.start = st; v.mode = m; v.budget = b; v.step = sp; v.halt = h;
    v.core_reset = cr; v.core_en = en; v.cnt = c; v.busy = bz; v.done = dn;
    vecs.push_back(v);
  endtask

  // ---------------- driver / checker tasks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] m, input logic [15:0] b);
    @(negedge clk);
    bus.start = 1'b1; bus.mode = m; bus.budget = b;
    tick();
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_cnt(input string name, input logic [15:0] target, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (bus.cycle_cnt == target) seen = 1'b1;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      tick();
      if (bus.done === 1'b1) seen = 1'b1;
    end
    check(name, seen, 1'b1);
  endtask

  task automatic pulse_halt();
    @(negedge clk);
    bus.halt = 1'b1;
    tick();
  endtask

  // ---------------- stimulus + scoreboard ----------------
  initial begin
    int n_rst, n_en, en0, rise0;
    logic seen;
    logic [15:0] d_cnt;
    logic d_busy, d_en;

    reset = 1'b1;
    bus.start = 0; bus.mode = 0; bus.budget = 0; bus.step = 0; bus.halt = 0;
    bus_s.start = 0; bus_s.mode = 0; bus_s.budget = 0; bus_s.step = 0; bus_s.halt = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_core_reset", bus.core_reset, 1'b1);
    check("rst_core_en",    bus.core_en,    1'b0);
    check("rst_cycle_cnt",  bus.cycle_cnt,  16'd0);
    check("rst_busy",       bus.busy,       1'b0);
    check("rst_done",       bus.done,       1'b0);
    @(negedge clk);
    reset = 1'b0;

    // {start, mode, budget, step, halt} -> {core_reset, core_en, cnt, busy, done}
    add_vec(1, 2'd1, 16'd3, 0, 0,  1, 0, 16'd0, 1, 0); // budget 3: RESET
    add_vec(0, 2'd1, 16'd3, 0, 0,  1, 0, 16'd0, 1, 0);
    add_vec(0, 2'd1, 16'd3, 0, 0,  0, 1, 16'd0, 1, 0); // RUN
    add_vec(0, 2'd1, 16'd3, 0, 0,  0, 1, 16'd1, 1, 0);
    add_vec(0, 2'd1, 16'd3, 0, 0,  0, 1, 16'd2, 1, 0);
    add_vec(0, 2'd1, 16'd3, 0, 0,  0, 0, 16'd3, 0, 1); // DONE pulse
    add_vec(0, 2'd1, 16'd3, 0, 0,  0, 0, 16'd3, 0, 0);
    add_vec(1, 2'd1, 16'd0, 0, 0,  1, 0, 16'd0, 1, 0); // budget 0
    add_vec(0, 2'd1, 16'd0, 0, 0,  1, 0, 16'd0, 1, 0);
    add_vec(0, 2'd1, 16'd0, 0, 0,  0, 0, 16'd0, 0, 1);
    add_vec(0, 2'd1, 16'd0, 0, 0,  0, 0, 16'd0, 0, 0);
    add_vec(1, 2'd3, 16'd7, 0, 0,  0, 0, 16'd0, 0, 0); // reserved mode ignored
    add_vec(1, 2'd2, 16'd0, 0, 0,  1, 0, 16'd0, 1, 0); // step mode
    add_vec(0, 2'd2, 16'd0, 0, 0,  1, 0, 16'd0, 1, 0);
    add_vec(0, 2'd2, 16'd0, 0, 0,  0, 0, 16'd0, 1, 0); // STEP_WAIT
    add_vec(0, 2'd2, 16'd0, 1, 0,  0, 1, 16'd0, 1, 0); // STEP
    add_vec(0, 2'd2, 16'd0, 1, 0,  0, 0, 16'd1, 1, 0); // held step: no 2nd step
    add_vec(0, 2'd2, 16'd0, 1, 0,  0, 0, 16'd1, 1, 0);
    add_vec(0, 2'd2, 16'd0, 0, 0,  0, 0, 16'd1, 1, 0);
    add_vec(0, 2'd2, 16'd0, 1, 0,  0, 1, 16'd1, 1, 0);
    add_vec(0, 2'd2, 16'd0, 0, 0,  0, 0, 16'd2, 1, 0);
    add_vec(1, 2'd1, 16'd5, 0, 0,  0, 0, 16'd2, 1, 0); // start while busy
    add_vec(0, 2'd1, 16'd5, 0, 1,  0, 0, 16'd2, 0, 1); // halt -> DONE
    add_vec(0, 2'd1, 16'd5, 0, 0,  0, 0, 16'd2, 0, 0);
    add_vec(1, 2'd0, 16'd0, 0, 0,  1, 0, 16'd0, 1, 0); // free-run
    add_vec(0, 2'd0, 16'd0, 0, 0,  1, 0, 16'd0, 1, 0);
    add_vec(0, 2'd0, 16'd0, 0, 0,  0, 1, 16'd0, 1, 0);
    add_vec(0, 2'd0, 16'd0, 0, 0,  0, 1, 16'd1, 1, 0);
    add_vec(0, 2'd0, 16'd0, 0, 1,  0, 0, 16'd2, 0, 1); // halt counts last cycle
    add_vec(0, 2'd0, 16'd0, 0, 0,  0, 0, 16'd2, 0, 0);
    add_vec(1, 2'd1, 16'd9, 0, 0,  1, 0, 16'd0, 1, 0); // halt during RESET
    add_vec(0, 2'd1, 16'd9, 0, 1,  0, 0, 16'd0, 0, 1);
    add_vec(0, 2'd1, 16'd9, 0, 0,  0, 0, 16'd0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      bus.start = vecs[i].start; bus.mode = vecs[i].mode; bus.budget = vecs[i].budget;
      bus.step = vecs[i].step; bus.halt = vecs[i].halt;
      tick();
      check($sformatf("vec%0d", i),
            {bus.core_reset, bus.core_en, bus.cycle_cnt, bus.busy, bus.done},
            {vecs[i].core_reset, vecs[i].core_en, vecs[i].cnt, vecs[i].busy, vecs[i].done});
    end
    @(negedge clk);
    bus.start = 0; bus.step = 0; bus.halt = 0;

    // Free-run halted after 20 enabled cycles.
    launch(2'd0, 16'd0);
    wait_cnt("free_reach19", 16'd19, 40);
    pulse_halt();
    check("free_done",    bus.done,      1'b1);
    check("free_cnt20",   bus.cycle_cnt, 16'd20);
    check("free_en_off",  bus.core_en,   1'b0);
    @(negedge clk);
    bus.halt = 0;

    // Budget 12, with a start attempt in the middle of the run.
    @(negedge clk);
    bus.start = 1; bus.mode = 2'd1; bus.budget = 16'd12;
    n_rst = 0; n_en = 0; seen = 0; d_cnt = '0; d_busy = 1'b1; d_en = 1'b1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (bus.core_reset) n_rst++;
      if (bus.core_en) n_en++;
      if (bus.done) begin
        seen = 1'b1; d_cnt = bus.cycle_cnt; d_busy = bus.busy; d_en = bus.core_en;
      end
      @(negedge clk);
      if (bus.core_en && bus.cycle_cnt == 16'd5) begin
        bus.start = 1; bus.mode = 2'd0; bus.budget = 16'd3;
      end else begin
        bus.start = 0;
      end
    end
    check("b12_done_seen", seen,   1'b1);
    check("b12_rst_cycles", n_rst, 32'd2);
    check("b12_en_cycles",  n_en,  32'd12);
    check("b12_done_cnt",   d_cnt, 16'd12);
    check("b12_done_busy",  d_busy, 1'b0);
    check("b12_done_en",    d_en,   1'b0);
    tick();
    check("b12_done_1cyc",  bus.done, 1'b0);

    // Halt on the final budget cycle.
    launch(2'd1, 16'd4);
    wait_cnt("hfin_reach3", 16'd3, 20);
    pulse_halt();
    check("hfin_done", bus.done,      1'b1);
    check("hfin_cnt",  bus.cycle_cnt, 16'd4);
    check("hfin_en",   bus.core_en,   1'b0);
    @(negedge clk);
    bus.halt = 0;

    // Single step: three short pulses and one held pulse.
    launch(2'd2, 16'd0);
    repeat (2) @(negedge clk);
    en0 = en_total; rise0 = rise_total;
    for (int k = 0; k < 3; k++) begin
      bus.step = 1;
      @(negedge clk);
      bus.step = 0;
      repeat (2) @(negedge clk);
    end
    bus.step = 1;
    repeat (4) @(negedge clk);
    bus.step = 0;
    repeat (3) @(negedge clk);
    check("step_en_cycles", en_total - en0,     32'd4);
    check("step_en_pulses", rise_total - rise0, 32'd4);
    check("step_cnt",       bus.cycle_cnt,      16'd4);
    bus.halt = 1;
    tick();
    check("step_halt_done", bus.done, 1'b1);
    @(negedge clk);
    bus.halt = 0;

    // Asynchronous reset in the middle of a free run.
    launch(2'd0, 16'd0);
    repeat (5) tick();
    #2;
    reset = 1'b1;
    #1;
    check("areset_en",    bus.core_en,    1'b0);
    check("areset_crst",  bus.core_reset, 1'b1);
    check("areset_cnt",   bus.cycle_cnt,  16'd0);
    check("areset_busy",  bus.busy,       1'b0);
    #9;
    reset = 1'b0;
    tick();
    check("areset_idle_crst", bus.core_reset, 1'b1);
    check("areset_idle_busy", bus.busy,       1'b0);
    launch(2'd1, 16'd2);
    wait_done("after_reset_done", 20);
    check("after_reset_cnt", bus.cycle_cnt, 16'd2);

    // Saturation on the 4-bit counter instance.
    @(negedge clk);
    bus_s.start = 1; bus_s.mode = 2'd0;
    @(negedge clk);
    bus_s.start = 0;
    repeat (34) @(negedge clk);
    check("sat_cnt", bus_s.cycle_cnt, 4'd15);
    check("sat_en",  bus_s.core_en,   1'b1);
    bus_s.halt = 1;
    tick();
    check("sat_halt_done", bus_s.done,      1'b1);
    check("sat_halt_cnt",  bus_s.cycle_cnt, 4'd15);
    @(negedge clk);
    bus_s.halt = 0;

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
